// File: rtl/uart_tx_fifo.sv
// UART transmitter with a one-deep holding register and valid/ready input.
// Configurable data width, optional parity and stop length; back-to-back frames.
module uart_tx_fifo #(
    parameter int DBIT      = 8,
    parameter int OVS       = 16,
    parameter int SB_TICK   = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [DBIT-1:0] data_in,
    input  logic            parity_odd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            par_bit;

    logic [DBIT-1:0] hold_data;
    logic            hold_odd;
    logic            hold_full;
    logic            drain;
    logic            hold_par;

    // The queued frame moves into the shifter when idle or on the last stop tick.
    assign drain = hold_full &&
                   ((state == IDLE) ||
                    ((state == STOP) && s_tick && (s == S_STOP)));

    assign hold_par = (^hold_data) ^ hold_odd;
    assign tx_ready = !hold_full;

    // Holding register: filled on handshake, emptied on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_odd  <= 1'b0;
        end else if (drain) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= data_in;
            hold_odd  <= parity_odd;
        end
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_busy      <= (state != IDLE);
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (hold_full) begin
                        state   <= START;
                        s       <= '0;
                        shift   <= hold_data;
                        par_bit <= hold_par;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shift <= shift >> 1;
                            if (n == N_LAST) begin
                                state <= PARITY_EN ? PARITY : STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    tx <= par_bit;
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            s            <= '0;
                            tx_done_tick <= 1'b1;
                            if (hold_full) begin
                                state   <= START;
                                shift   <= hold_data;
                                par_bit <= hold_par;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations share clock, tick and reset.
// Frames are queued on write and checked bit by bit at mid-bit when sent.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    bit         tick_en = 1'b1;
    logic [2:0] valid_v = '0;
    logic [2:0] odd_v = '0;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic [6:0] d2 = '0;
    logic [2:0] tx_w;
    logic [2:0] rdy_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    logic last_tick = 1'b0;
    int   done_cnt [3] = '{0, 0, 0};

    typedef struct {
        logic [8:0] data;
        logic       odd;
        int         dbits;
        int         pen;
        int         len;
    } frame_t;

    frame_t     sb_q [$];
    int         pend_which = 0;
    logic [8:0] pend_data = '0;
    logic       pend_odd = 1'b0;

    uart_tx_fifo u0 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick),
        .tx_valid(valid_v[0]), .tx_ready(rdy_w[0]),
        .data_in(d0), .parity_odd(odd_v[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
    );

    uart_tx_fifo #(.PARITY_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick),
        .tx_valid(valid_v[1]), .tx_ready(rdy_w[1]),
        .data_in(d1), .parity_odd(odd_v[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
    );

    uart_tx_fifo #(.DBIT(7), .SB_TICK(32)) u2 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick),
        .tx_valid(valid_v[2]), .tx_ready(rdy_w[2]),
        .data_in(d2), .parity_odd(odd_v[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2])
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clks, changed on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = tick_en;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Tick and done-pulse counters.
    always @(posedge clk) begin
        if (s_tick) tick_cnt <= tick_cnt + 1;
        last_tick <= s_tick;
        for (int i = 0; i < 3; i++)
            if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int target);
        int g;
        g = 0;
        while (tick_cnt < target && g < 50000) begin
            @(negedge clk);
            g++;
        end
        if (tick_cnt < target) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout: got %0d expected %0d", tick_cnt, target);
        end
    endtask

    task automatic send(input int w, input logic [8:0] d, input logic odd,
                        input bit fast);
        frame_t f;
        @(negedge clk);
        chk("ready_pre", rdy_w[w], 1);
        if (w == 0) d0 = d[7:0];
        else if (w == 1) d1 = d[7:0];
        else d2 = d[6:0];
        odd_v[w] = odd;
        valid_v[w] = 1'b1;
        @(negedge clk);
        valid_v[w] = 1'b0;
        odd_v[w] = ~odd;
        if (w == 0) d0 = ~d[7:0];
        else if (w == 1) d1 = ~d[7:0];
        else d2 = ~d[6:0];
        chk("ready_held", rdy_w[w], 0);
        if (fast) begin
            @(negedge clk);
            chk("ready_back", rdy_w[w], 1);
        end
        f.data  = d;
        f.odd   = odd;
        f.dbits = (w == 2) ? 7 : 8;
        f.pen   = (w == 1) ? 1 : 0;
        f.len   = (1 + f.dbits + f.pen) * 16 + ((w == 2) ? 32 : 16);
        sb_q.push_back(f);
    endtask

    task automatic rx_frame(input int w, input int sb, input int stall,
                            input int wr, input bit idle_after,
                            output int t0, output int t_end);
        frame_t f;
        int     g;
        int     nb;
        int     dc0;
        int     bad;
        logic   eb;
        t0 = 0;
        t_end = 0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rx_queue: got empty expected a frame");
            return;
        end
        f = sb_q.pop_front();
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tx_w[w] !== 1'b0 && g < 20000);
        if (tx_w[w] !== 1'b0) begin
            checks++;
            errors++;
            $error("FAIL rx_start: got %b expected 0", tx_w[w]);
            return;
        end
        t0 = tick_cnt - int'(last_tick);
        dc0 = done_cnt[w];
        chk("busy_start", busy_w[w], 1);
        if (stall > 0) begin
            wait_tick(t0 + stall);
            tick_en = 1'b0;
            bad = 0;
            repeat (1000) begin
                @(negedge clk);
                if (tx_w[w] !== 1'b0 || busy_w[w] !== 1'b1) bad++;
            end
            chk("stall_hold", bad, 0);
            tick_en = 1'b1;
        end
        nb = 1 + f.dbits + f.pen;
        for (int k = 0; k < nb; k++) begin
            if (wr > 0 && k == wr) send(pend_which, pend_data, pend_odd, 1'b0);
            wait_tick(t0 + k * 16 + 8);
            if (k == 0) begin
                eb = 1'b0;
            end else if (k <= f.dbits) begin
                eb = f.data[k-1];
            end else begin
                eb = f.odd;
                for (int j = 0; j < f.dbits; j++) eb = eb ^ f.data[j];
            end
            chk($sformatf("bit%0d", k), tx_w[w], eb);
        end
        wait_tick(t0 + nb * 16 + sb / 2);
        chk("stop", tx_w[w], 1);
        g = 0;
        while (done_w[w] !== 1'b1 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (done_w[w] !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL done_timeout: got %b expected 1", done_w[w]);
            return;
        end
        t_end = tick_cnt;
        chk("frame_len", tick_cnt - t0, f.len);
        @(negedge clk);
        chk("done_width", done_w[w], 0);
        chk("done_count", done_cnt[w] - dc0, 1);
        if (idle_after) chk("busy_idle", busy_w[w], 0);
    endtask

    initial begin
        int ta;
        int tb;
        int t0;
        int te;
        int g;
        int dc;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", tx_w[i], 1);
            chk("rst_ready", rdy_w[i], 1);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 frame
        send(0, 9'h0A5, 1'b0, 1'b1);
        rx_frame(0, 16, 0, 0, 1'b1, ta, te);

        // parity even, then odd
        send(1, 9'h007, 1'b0, 1'b1);
        rx_frame(1, 16, 0, 0, 1'b1, ta, te);
        send(1, 9'h007, 1'b1, 1'b1);
        rx_frame(1, 16, 0, 0, 1'b1, ta, te);

        // back-to-back frames, second written during data
        pend_which = 0;
        pend_data = 9'h0F0;
        pend_odd = 1'b0;
        send(0, 9'h055, 1'b0, 1'b1);
        rx_frame(0, 16, 0, 4, 1'b0, ta, te);
        chk("ready_after_drain", rdy_w[0], 1);
        rx_frame(0, 16, 0, 0, 1'b1, tb, t0);
        chk("no_gap", tb, te);

        // 7 data bits, two stop bits
        send(2, 9'h07F, 1'b0, 1'b1);
        rx_frame(2, 32, 0, 0, 1'b1, ta, te);

        // reset mid-data with hold full
        send(0, 9'h03C, 1'b0, 1'b1);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tx_w[0] !== 1'b0 && g < 20000);
        chk("rst_pre_start", tx_w[0], 0);
        t0 = tick_cnt - int'(last_tick);
        wait_tick(t0 + 40);
        send(0, 9'h0C3, 1'b0, 1'b0);
        chk("rst_pre_tx", tx_w[0], 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", tx_w[0], 1);
        chk("arst_ready", rdy_w[0], 1);
        chk("arst_busy", busy_w[0], 0);
        sb_q.delete();
        dc = done_cnt[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("arst_no_done", done_cnt[0] - dc, 0);
        chk("arst_idle_tx", tx_w[0], 1);
        send(0, 9'h081, 1'b0, 1'b1);
        rx_frame(0, 16, 0, 0, 1'b1, ta, te);

        // tick stall during start
        send(0, 9'h05A, 1'b1, 1'b1);
        rx_frame(0, 16, 5, 0, 1'b1, ta, te);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
